// File: rtl/ex_flag_stage_if.sv
// rtl/ex_flag_stage_if.sv - EX-stage control/data bundle between the execute pipe and the flag stage
interface ex_flag_stage_if #(parameter int DW = 16);
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] alu_result;
    logic          alu_v;
    logic          alu_n;
    logic [3:0]    alu_ctrl;
    logic          flag_we;
    logic          br_en;
    logic [2:0]    br_cond;
    logic [DW-1:0] br_target;
    logic [DW-1:0] mem_result;
    logic          mem_valid;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;
    logic          branch_taken;
    logic [DW-1:0] branch_pc;

    modport master (
        output stall, flush, ex_valid, alu_result, alu_v, alu_n, alu_ctrl,
               flag_we, br_en, br_cond, br_target,
        input  mem_result, mem_valid, flag_z, flag_v, flag_n, branch_taken, branch_pc
    );

    modport slave (
        input  stall, flush, ex_valid, alu_result, alu_v, alu_n, alu_ctrl,
               flag_we, br_en, br_cond, br_target,
        output mem_result, mem_valid, flag_z, flag_v, flag_n, branch_taken, branch_pc
    );
endinterface

// File: rtl/ex_flag_stage.sv
// rtl/ex_flag_stage.sv - EX/MEM register, Z/V/N flag register and branch redirect with shadow squash
module ex_flag_stage #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    ex_flag_stage_if.slave    bus
);

    logic [DW-1:0] mem_result_q, mem_result_d;
    logic          mem_valid_q, mem_valid_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_v_q, flag_v_d;
    logic          flag_n_q, flag_n_d;
    logic          branch_taken_q, branch_taken_d;
    logic [DW-1:0] branch_pc_q, branch_pc_d;
    logic          shadow_q, shadow_d;

    logic ev;
    logic alu_zero;
    logic cond_true;
    logic take;

    assign ev       = bus.ex_valid & ~bus.flush & ~shadow_q;
    assign alu_zero = (bus.alu_result == '0);

    // Conditions read the committed flags; a setter one slot ahead has already written them.
    always_comb begin
        cond_true = 1'b0;
        unique case (bus.br_cond)
            3'b000: cond_true = ~flag_z_q;
            3'b001: cond_true = flag_z_q;
            3'b010: cond_true = ~flag_z_q & ~flag_n_q;
            3'b011: cond_true = flag_n_q;
            3'b100: cond_true = flag_z_q | ~flag_n_q;
            3'b101: cond_true = flag_n_q | flag_z_q;
            3'b110: cond_true = flag_v_q;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign take = ~bus.stall & ev & bus.br_en & cond_true;

    always_comb begin
        mem_result_d   = mem_result_q;
        mem_valid_d    = mem_valid_q;
        flag_z_d       = flag_z_q;
        flag_v_d       = flag_v_q;
        flag_n_d       = flag_n_q;
        branch_taken_d = 1'b0;
        branch_pc_d    = branch_pc_q;
        shadow_d       = shadow_q;

        if (!bus.stall) begin
            mem_result_d = bus.alu_result;
            mem_valid_d  = ev & ~bus.br_en;
            shadow_d     = take;
            if (take) begin
                branch_taken_d = 1'b1;
                branch_pc_d    = bus.br_target;
            end
            if (ev && bus.flag_we && !bus.br_en) begin
                flag_z_d = alu_zero;
                // Only the adder produces meaningful overflow/sign; logic and shift units keep V/N.
                if (bus.alu_ctrl[3:2] == 2'b00) begin
                    flag_v_d = bus.alu_v;
                    flag_n_d = bus.alu_n;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_result_q   <= '0;
            mem_valid_q    <= 1'b0;
            flag_z_q       <= 1'b0;
            flag_v_q       <= 1'b0;
            flag_n_q       <= 1'b0;
            branch_taken_q <= 1'b0;
            branch_pc_q    <= '0;
            shadow_q       <= 1'b0;
        end else begin
            mem_result_q   <= mem_result_d;
            mem_valid_q    <= mem_valid_d;
            flag_z_q       <= flag_z_d;
            flag_v_q       <= flag_v_d;
            flag_n_q       <= flag_n_d;
            branch_taken_q <= branch_taken_d;
            branch_pc_q    <= branch_pc_d;
            shadow_q       <= shadow_d;
        end
    end

    assign bus.mem_result   = mem_result_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.flag_z       = flag_z_q;
    assign bus.flag_v       = flag_v_q;
    assign bus.flag_n       = flag_n_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.branch_pc    = branch_pc_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// tb/tb_ex_flag_stage.sv - directed self-checking bench for ex_flag_stage
module tb_ex_flag_stage;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   failed;

    ex_flag_stage_if #(.DW(DW)) bus ();

    ex_flag_stage #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [DW-1:0] res, input logic v, input logic n,
                         input logic [3:0] ctrl, input logic fwe, input logic ben,
                         input logic [2:0] cond, input logic [DW-1:0] tgt);
        bus.ex_valid   = vld;
        bus.alu_result = res;
        bus.alu_v      = v;
        bus.alu_n      = n;
        bus.alu_ctrl   = ctrl;
        bus.flag_we    = fwe;
        bus.br_en      = ben;
        bus.br_cond    = cond;
        bus.br_target  = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags();
        return {bus.flag_z, bus.flag_v, bus.flag_n};
    endfunction

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(0, 16'h0000, 0, 0, 4'b0000, 0, 0, 3'b000, 16'h0000);
        tick();
        tick();
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_flags", flags(), 3'b000);
        check("rst_branch_taken", bus.branch_taken, 1'b0);
        check("rst_branch_pc", bus.branch_pc, 16'h0000);
        rst = 1'b0;

        // build state flags=111, mem_valid=1, then reset mid-cycle
        drive(1, 16'h0000, 1, 1, 4'b0000, 1, 0, 3'b000, 16'h0000);
        tick();
        check("pre_rst_flags", flags(), 3'b111);
        check("pre_rst_mem_valid", bus.mem_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags", flags(), 3'b000);
        check("async_rst_mem_valid", bus.mem_valid, 1'b0);
        tick();
        rst = 1'b0;
        drive(1, 16'h0005, 0, 0, 4'b0000, 0, 0, 3'b000, 16'h0000);
        tick();
        check("post_rst_mem_valid", bus.mem_valid, 1'b1);
        check("post_rst_mem_result", bus.mem_result, 16'h0005);

        // flag rules: ADD writes all three, XOR writes Z only
        drive(1, 16'h0000, 1, 0, 4'b0000, 1, 0, 3'b000, 16'h0000);
        tick();
        check("add_flags", flags(), 3'b110);
        drive(1, 16'h8001, 0, 1, 4'b1000, 1, 0, 3'b000, 16'h0000);
        tick();
        check("xor_flags", flags(), 3'b010);

        // SUB sets N, LT branch sees it, next instruction squashed
        drive(1, 16'hFFFE, 0, 1, 4'b0001, 1, 0, 3'b000, 16'h0000);
        tick();
        check("sub_flags", flags(), 3'b001);
        drive(1, 16'h0000, 0, 0, 4'b0000, 0, 1, 3'b011, 16'h0040);
        tick();
        check("lt_taken", bus.branch_taken, 1'b1);
        check("lt_pc", bus.branch_pc, 16'h0040);
        check("lt_mem_valid", bus.mem_valid, 1'b0);
        drive(1, 16'h0000, 0, 0, 4'b0000, 1, 0, 3'b000, 16'h0000);
        tick();
        check("lt_pulse_end", bus.branch_taken, 1'b0);
        check("shadow_mem_valid", bus.mem_valid, 1'b0);
        check("shadow_flags", flags(), 3'b001);

        // not-taken branch does not squash its successor
        drive(1, 16'h0000, 0, 0, 4'b0000, 1, 0, 3'b000, 16'h0000);
        tick();
        check("setz_flags", flags(), 3'b100);
        drive(1, 16'h0000, 0, 0, 4'b0000, 0, 1, 3'b000, 16'h0099);
        tick();
        check("ne_not_taken", bus.branch_taken, 1'b0);
        check("ne_mem_valid", bus.mem_valid, 1'b0);
        drive(1, 16'h0007, 0, 0, 4'b0000, 0, 0, 3'b000, 16'h0000);
        tick();
        check("after_nt_mem_valid", bus.mem_valid, 1'b1);
        check("after_nt_mem_result", bus.mem_result, 16'h0007);

        // stalled taken branch: no pulse during stall, single pulse after release
        drive(1, 16'h0000, 0, 0, 4'b0000, 0, 1, 3'b001, 16'h1234);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_pulse", bus.branch_taken, 1'b0);
            check("stall_hold_mem_valid", bus.mem_valid, 1'b1);
        end
        bus.stall = 1'b0;
        tick();
        check("eq_taken", bus.branch_taken, 1'b1);
        check("eq_pc", bus.branch_pc, 16'h1234);

        // stall during shadow: shadow persists
        drive(1, 16'h0001, 1, 1, 4'b0000, 1, 0, 3'b000, 16'h0000);
        bus.stall = 1'b1;
        tick();
        check("shadow_stall_pulse", bus.branch_taken, 1'b0);
        tick();
        check("shadow_stall_mem_valid", bus.mem_valid, 1'b0);
        bus.stall = 1'b0;
        tick();
        check("shadow_stall_squash_mv", bus.mem_valid, 1'b0);
        check("shadow_stall_squash_flags", flags(), 3'b100);
        drive(1, 16'h0009, 0, 0, 4'b0000, 0, 0, 3'b000, 16'h0000);
        tick();
        check("shadow_cleared_mv", bus.mem_valid, 1'b1);

        // flush blocks flag write and mem_valid but result still passes
        drive(1, 16'h8000, 1, 1, 4'b0000, 1, 0, 3'b000, 16'h0000);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_flags", flags(), 3'b100);
        check("flush_mem_valid", bus.mem_valid, 1'b0);
        check("flush_mem_result", bus.mem_result, 16'h8000);

        // back-to-back unconditional branches: only the first redirects
        drive(1, 16'h0000, 0, 0, 4'b0000, 0, 1, 3'b111, 16'h00AA);
        tick();
        check("alw1_taken", bus.branch_taken, 1'b1);
        check("alw1_pc", bus.branch_pc, 16'h00AA);
        drive(1, 16'h0000, 0, 0, 4'b0000, 0, 1, 3'b111, 16'h00BB);
        tick();
        check("alw2_squashed", bus.branch_taken, 1'b0);
        check("alw2_pc_hold", bus.branch_pc, 16'h00AA);
        drive(0, 16'h0000, 0, 0, 4'b0000, 0, 0, 3'b000, 16'h0000);
        tick();
        check("alw_idle", bus.branch_taken, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
